// File: rtl/pixel_write_sink.sv
// Pixel-write sink: bounds-checks incoming (x, y, colour) beats against the
// visible area, turns each legal beat into a linear framebuffer address, holds
// it in a small show-ahead FIFO and hands it to the framebuffer memory port
// with valid/ready handshaking so memory stalls never lose a pixel.
module pixel_write_sink #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COLOR_W = 9,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         vga_x,
  input  logic [8:0]         vga_y,
  input  logic [COLOR_W-1:0] vga_color,
  input  logic               vga_write,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic               overflow,
  output logic               oob,
  input  logic               clr_status,
  output logic [ADDR_W-1:0]  pix_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Input-side decode
  logic              in_range;
  logic              accept;
  logic              take_pixel;
  logic              drop_full;
  logic              drop_oob;
  logic [ADDR_W-1:0] addr_calc;
  logic [CntW:0]     occupancy;

  // Stage register between address calculation and the FIFO
  logic               stage_valid_q;
  logic [ADDR_W-1:0]  stage_addr_q;
  logic [COLOR_W-1:0] stage_color_q;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0]  fifo_addr_q  [DEPTH];
  logic [COLOR_W-1:0] fifo_color_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // Status
  logic              overflow_q, overflow_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] pix_count_q, pix_count_d;

  // Range check done at full precision so non-default resolutions stay correct.
  assign in_range = (32'(vga_x) < H_RES) && (32'(vga_y) < V_RES);

  // Capacity only looks at registered state; a same-cycle pop earns no credit.
  assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, stage_valid_q};
  assign in_ready   = occupancy < (CntW + 1)'(DEPTH);

  assign accept     = vga_write & in_ready;
  assign take_pixel = accept & in_range;
  assign drop_full  = vga_write & ~in_ready;
  assign drop_oob   = accept & ~in_range;

  // y*640 = (y<<9)+(y<<7) for the default width; otherwise a plain multiply.
  if (H_RES == 640) begin : g_shift_add
    assign addr_calc = (ADDR_W'(vga_y) << 9) + (ADDR_W'(vga_y) << 7) + ADDR_W'(vga_x);
  end else begin : g_mul
    assign addr_calc = ADDR_W'(vga_y) * ADDR_W'(H_RES) + ADDR_W'(vga_x);
  end

  assign fifo_empty = (count_q == '0);
  assign push       = stage_valid_q;
  assign pop        = ~fifo_empty & mem_ready;

  // Stage register: latch address and colour of each accepted in-range beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_color_q <= '0;
    end else begin
      stage_valid_q <= take_pixel;
      if (take_pixel) begin
        stage_addr_q  <= addr_calc;
        stage_color_q <= vga_color;
      end
    end
  end

  // FIFO payload storage; contents are don't-care while the entry is unused.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= stage_addr_q;
      fifo_color_q[wr_ptr_q] <= stage_color_q;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset discards anything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sticky flags (a set in the same cycle as a clear wins) and accepted-pixel counter.
  always_comb begin
    overflow_d  = overflow_q;
    oob_d       = oob_q;
    pix_count_d = pix_count_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      oob_d      = 1'b0;
    end
    if (drop_full) overflow_d = 1'b1;
    if (drop_oob)  oob_d      = 1'b1;
    if (take_pixel) pix_count_d = pix_count_q + ADDR_W'(1);
  end

  // Status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      oob_q       <= 1'b0;
      pix_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      oob_q       <= oob_d;
      pix_count_q <= pix_count_d;
    end
  end

  // Show-ahead head; gated so outputs read zero whenever nothing is queued.
  assign mem_we    = ~fifo_empty;
  assign mem_addr  = mem_we ? fifo_addr_q[rd_ptr_q]  : '0;
  assign mem_data  = mem_we ? fifo_color_q[rd_ptr_q] : '0;

  assign busy      = stage_valid_q | ~fifo_empty;
  assign overflow  = overflow_q;
  assign oob       = oob_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: directed scenarios plus randomized backpressure,
// scored against a queue of expected (address, colour) writes and sticky-flag model.
module tb_pixel_write_sink;

  localparam int unsigned H_RES   = 640;
  localparam int unsigned V_RES   = 480;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned COLOR_W = 9;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned WordW   = ADDR_W + COLOR_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [9:0]         vga_x;
  logic [8:0]         vga_y;
  logic [COLOR_W-1:0] vga_color;
  logic               vga_write;
  logic               in_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_we;
  logic               mem_ready;
  logic               busy;
  logic               overflow;
  logic               oob;
  logic               clr_status;
  logic [ADDR_W-1:0]  pix_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [WordW-1:0]  exp_q[$];
  logic              ovf_exp    = 1'b0;
  logic              oob_exp    = 1'b0;
  logic [ADDR_W-1:0] pix_exp    = '0;
  int unsigned       n_writes   = 0;
  int unsigned       n_accepts  = 0;
  logic              stall_prev = 1'b0;
  logic [WordW-1:0]  stall_word = '0;
  logic [WordW-1:0]  head_word;
  logic [ADDR_W-1:0] model_addr;

  pixel_write_sink #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .DEPTH  (DEPTH),
    .COLOR_W(COLOR_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_color (vga_color),
    .vga_write (vga_write),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .busy      (busy),
    .overflow  (overflow),
    .oob       (oob),
    .clr_status(clr_status),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Model: at each falling edge check DUT state against expectations, then apply
  // the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      ovf_exp    = 1'b0;
      oob_exp    = 1'b0;
      pix_exp    = '0;
      stall_prev = 1'b0;
    end else begin
      check_eq("overflow", 32'(overflow), 32'(ovf_exp));
      check_eq("oob", 32'(oob), 32'(oob_exp));
      check_eq("pix_count", 32'(pix_count), 32'(pix_exp));

      if (stall_prev)
        check_eq("stall_hold", 32'({mem_we, mem_addr, mem_data}), 32'({1'b1, stall_word}));
      stall_prev = mem_we && !mem_ready;
      stall_word = {mem_addr, mem_data};

      if (mem_we && mem_ready) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          head_word = exp_q.pop_front();
          check_eq("wr_addr", 32'(mem_addr), 32'(head_word[WordW-1:COLOR_W]));
          check_eq("wr_data", 32'(mem_data), 32'(head_word[COLOR_W-1:0]));
        end
      end

      if (clr_status) begin
        ovf_exp = 1'b0;
        oob_exp = 1'b0;
      end
      if (vga_write) begin
        if (!in_ready) begin
          ovf_exp = 1'b1;
        end else begin
          n_accepts++;
          if (int'(vga_x) < int'(H_RES) && int'(vga_y) < int'(V_RES)) begin
            model_addr = ADDR_W'(int'(vga_y) * int'(H_RES) + int'(vga_x));
            exp_q.push_back({model_addr, vga_color});
            pix_exp = pix_exp + 1'b1;
          end else begin
            oob_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int x, input int y, input int c);
    vga_x     = 10'(x);
    vga_y     = 9'(y);
    vga_color = COLOR_W'(c);
    vga_write = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) break;
    end
    check_eq("drain_queue", exp_q.size(), 0);
    check_eq("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_clear();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    int unsigned a0;
    int unsigned drops;
    logic [ADDR_W-1:0] p0;
    int rows [4] = '{0, 1, 2, 479};

    reset      = 1'b1;
    vga_x      = '0;
    vga_y      = '0;
    vga_color  = '0;
    vga_write  = 1'b0;
    mem_ready  = 1'b1;
    clr_status = 1'b0;

    // Reset values
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_data", 32'(mem_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_flags", 32'({overflow, oob}), 32'd0);
    check_eq("rst_pix_count", 32'(pix_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: single pixel and latency
    set_beat(5, 2, 'h1FF);
    tick();
    vga_write = 1'b0;
    check_eq("lat_edge_n_we", 32'(mem_we), 32'd0);
    check_eq("lat_edge_n_busy", 32'(busy), 32'd1);
    tick();
    check_eq("lat_edge_n1_we", 32'(mem_we), 32'd1);
    check_eq("single_addr", 32'(mem_addr), 32'd1285);
    check_eq("single_data", 32'(mem_data), 32'h1FF);
    tick();
    check_eq("lat_edge_n2_we", 32'(mem_we), 32'd0);
    check_eq("single_busy", 32'(busy), 32'd0);
    check_eq("single_pix", 32'(pix_count), 32'd1);

    // 2: boundaries
    set_beat(639, 479, 3);
    tick();
    set_beat(640, 0, 4);
    tick();
    set_beat(0, 480, 5);
    tick();
    vga_write = 1'b0;
    drain(20);
    check_eq("bound_oob", 32'(oob), 32'd1);
    check_eq("bound_pix", 32'(pix_count), 32'd2);
    pulse_clear();
    check_eq("bound_oob_clr", 32'(oob), 32'd0);
    set_beat(700, 10, 0);
    clr_status = 1'b1;
    tick();
    vga_write  = 1'b0;
    clr_status = 1'b0;
    check_eq("oob_set_wins", 32'(oob), 32'd1);
    pulse_clear();
    check_eq("oob_clr_again", 32'(oob), 32'd0);

    // 3: stall and fill
    mem_ready = 1'b0;
    a0 = n_accepts;
    for (int i = 0; i < 6; i++) begin
      set_beat(10 + i, 20, i + 1);
      tick();
      if (i == 3) check_eq("fill_in_ready_low", 32'(in_ready), 32'd0);
    end
    vga_write = 1'b0;
    check_eq("fill_accepted", n_accepts - a0, 4);
    check_eq("fill_overflow", 32'(overflow), 32'd1);
    check_eq("fill_head_addr", 32'(mem_addr), 32'd12810);
    repeat (3) tick();
    check_eq("fill_we_held", 32'(mem_we), 32'd1);
    w0 = n_writes;
    mem_ready = 1'b1;
    drain(20);
    check_eq("fill_writes", n_writes - w0, 4);
    pulse_clear();
    check_eq("fill_ovf_clr", 32'(overflow), 32'd0);

    // 4: raster stream (first rows and last row) at full rate
    w0 = n_writes;
    p0 = pix_count;
    drops = 0;
    foreach (rows[r]) begin
      for (int x = 0; x < int'(H_RES); x++) begin
        if (!in_ready) drops++;
        set_beat(x, rows[r], (x + rows[r]) & 511);
        tick();
      end
    end
    vga_write = 1'b0;
    drain(20);
    check_eq("stream_no_stall", drops, 0);
    check_eq("stream_writes", n_writes - w0, 4 * H_RES);
    check_eq("stream_overflow", 32'(overflow), 32'd0);
    check_eq("stream_pix", 32'(ADDR_W'(pix_count - p0)), 4 * H_RES);

    // 5: random backpressure, source obeys in_ready
    for (int i = 0; i < 2000; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && in_ready)
        set_beat($urandom_range(0, 659), $urandom_range(0, 489), $urandom_range(0, 511));
      else
        vga_write = 1'b0;
      clr_status = ($urandom_range(0, 63) == 0);
      tick();
    end
    vga_write  = 1'b0;
    clr_status = 1'b0;
    mem_ready  = 1'b1;
    drain(50);
    check_eq("rand_no_overflow", 32'(overflow), 32'd0);

    // 6: async reset with entries buffered under stall
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(100 + i, 7, 50 + i);
      tick();
    end
    vga_write = 1'b0;
    repeat (2) tick();
    check_eq("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_mem_we", 32'(mem_we), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("arst_pix_count", 32'(pix_count), 32'd0);
    @(negedge clk);
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    repeat (8) begin
      tick();
      check_eq("post_rst_we", 32'(mem_we), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
